// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM state encoding and access-owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_e;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic CHIP_ENABLE = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one async-style SRAM between the IF fetch port and the MEM load/store port.
// MEM has fixed priority; an access runs IDLE -> ACCESS (WAIT_CYCLES) -> DONE without pre-emption.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_ce,
  input  logic [31:0]       i_inst_addr,
  output logic [31:0]       o_inst_rdata,
  output logic              o_stallreq_if,
  input  logic              i_data_ce,
  input  logic              i_data_we,
  input  logic [31:0]       i_data_addr,
  input  logic [3:0]        i_data_sel,
  input  logic [31:0]       i_data_wdata,
  output logic [31:0]       o_data_rdata,
  output logic              o_stallreq_mem,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [3:0]        o_ram_be_n,
  output logic              o_ram_ce_n,
  output logic              o_ram_oe_n,
  output logic              o_ram_we_n,
  output logic [31:0]       o_ram_wdata,
  output logic              o_ram_wdata_oe,
  input  logic [31:0]       i_ram_rdata
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  arb_state_e        r_state, w_state_nxt;
  arb_owner_e        r_owner;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [RAM_AW-1:0] r_addr;
  logic [3:0]        r_be_n;
  logic [31:0]       r_wdata;
  logic              r_ce_n, r_oe_n, r_we_n, r_wdata_oe;
  logic [31:0]       r_inst_rdata, r_data_rdata;

  logic w_grant_mem, w_grant_if, w_cnt_last;
  logic w_if_done, w_mem_done;
  logic w_unused;

  // Byte offset and bits above the SRAM window are deliberately dropped.
  assign w_unused = ^{i_inst_addr[1:0], i_inst_addr[31:RAM_AW+2],
                      i_data_addr[1:0], i_data_addr[31:RAM_AW+2]};

  assign w_cnt_last = (r_cnt == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) r_state <= ARB_IDLE;
    else                     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (i_data_ce == CHIP_ENABLE) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ARB_ACCESS;
        end else if (i_inst_ce == CHIP_ENABLE) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: if (w_cnt_last) w_state_nxt = ARB_DONE;
      ARB_DONE:   w_state_nxt = ARB_IDLE;
      default:    w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_owner      <= OWN_NONE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be_n       <= 4'hF;
      r_wdata      <= '0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_wdata_oe   <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_mem) begin
            r_owner    <= OWN_MEM;
            r_addr     <= i_data_addr[RAM_AW+1:2];
            r_be_n     <= ~i_data_sel;
            r_wdata    <= i_data_wdata;
            r_we       <= i_data_we;
            r_oe_n     <= i_data_we;
            r_we_n     <= ~i_data_we;
            r_wdata_oe <= i_data_we;
          end else if (w_grant_if) begin
            r_owner    <= OWN_IF;
            r_addr     <= i_inst_addr[RAM_AW+1:2];
            r_be_n     <= 4'h0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_oe_n     <= 1'b0;
            r_we_n     <= 1'b1;
            r_wdata_oe <= 1'b0;
          end
          if (w_grant_mem || w_grant_if) begin
            r_cnt  <= '0;
            r_ce_n <= 1'b0;
          end
        end
        ARB_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_cnt_last) begin
            r_ce_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            // Capture happens even if the requester has since dropped ce.
            if (!r_we) begin
              if (r_owner == OWN_IF)  r_inst_rdata <= i_ram_rdata;
              if (r_owner == OWN_MEM) r_data_rdata <= i_ram_rdata;
            end
          end
        end
        ARB_DONE: begin
          // wdata_oe was held through DONE for bus hold time; release it now.
          r_wdata_oe <= 1'b0;
          r_owner    <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

  assign w_if_done  = (r_state == ARB_DONE) && (r_owner == OWN_IF);
  assign w_mem_done = (r_state == ARB_DONE) && (r_owner == OWN_MEM);

  assign o_stallreq_if  = (i_rst != RST_ENABLE) && i_inst_ce && !w_if_done;
  assign o_stallreq_mem = (i_rst != RST_ENABLE) && i_data_ce && !w_mem_done;

  assign o_inst_rdata   = r_inst_rdata;
  assign o_data_rdata   = r_data_rdata;
  assign o_ram_addr     = r_addr;
  assign o_ram_be_n     = r_be_n;
  assign o_ram_ce_n     = r_ce_n;
  assign o_ram_oe_n     = r_oe_n;
  assign o_ram_we_n     = r_we_n;
  assign o_ram_wdata    = r_wdata;
  assign o_ram_wdata_oe = r_wdata_oe;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner sequences, a transaction table, and a
// randomized run checked every cycle against a transaction-age reference model.
module tb_mem_arbiter;
  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_ce, data_ce, data_we;
  logic [31:0]   inst_addr, data_addr, data_wdata, ram_rdata;
  logic [3:0]    data_sel;
  logic [31:0]   o_inst_rdata, o_data_rdata, o_ram_wdata;
  logic          o_stallreq_if, o_stallreq_mem;
  logic [AW-1:0] o_ram_addr;
  logic [3:0]    o_ram_be_n;
  logic          o_ram_ce_n, o_ram_oe_n, o_ram_we_n, o_ram_wdata_oe;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W), .RAM_AW(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_ce(inst_ce), .i_inst_addr(inst_addr), .o_inst_rdata(o_inst_rdata),
    .o_stallreq_if(o_stallreq_if),
    .i_data_ce(data_ce), .i_data_we(data_we), .i_data_addr(data_addr),
    .i_data_sel(data_sel), .i_data_wdata(data_wdata), .o_data_rdata(o_data_rdata),
    .o_stallreq_mem(o_stallreq_mem),
    .o_ram_addr(o_ram_addr), .o_ram_be_n(o_ram_be_n), .o_ram_ce_n(o_ram_ce_n),
    .o_ram_oe_n(o_ram_oe_n), .o_ram_we_n(o_ram_we_n), .o_ram_wdata(o_ram_wdata),
    .o_ram_wdata_oe(o_ram_wdata_oe), .i_ram_rdata(ram_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction with an age counter since grant
  // (0 = no access, 1..W = strobes active, W+1 = completion cycle).
  int            m_age = 0;
  int            m_own = 0;   // 0 none, 1 IF, 2 MEM
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]    m_be  = 4'hF;
  logic [31:0]   m_wd  = '0, m_ir = '0, m_dr = '0;
  logic          m_acc, m_dn;
  assign m_acc = (m_age >= 1) && (m_age <= W);
  assign m_dn  = (m_age == W + 1);

  always @(negedge clk) begin
    chk("ram_ce_n",     32'(o_ram_ce_n),     32'(!m_acc));
    chk("ram_oe_n",     32'(o_ram_oe_n),     32'(!(m_acc && !m_we)));
    chk("ram_we_n",     32'(o_ram_we_n),     32'(!(m_acc && m_we)));
    chk("ram_wdata_oe", 32'(o_ram_wdata_oe), 32'(m_we && (m_acc || m_dn)));
    chk("ram_addr",     32'(o_ram_addr),     32'(m_addr));
    chk("ram_be_n",     32'(o_ram_be_n),     32'(m_be));
    chk("ram_wdata",    o_ram_wdata,         m_wd);
    chk("inst_rdata",   o_inst_rdata,        m_ir);
    chk("data_rdata",   o_data_rdata,        m_dr);
    chk("stallreq_if",  32'(o_stallreq_if),  32'(!rst && inst_ce && !(m_dn && m_own == 1)));
    chk("stallreq_mem", 32'(o_stallreq_mem), 32'(!rst && data_ce && !(m_dn && m_own == 2)));
    if (rst) begin
      m_age <= 0; m_own <= 0; m_we <= 1'b0; m_addr <= '0; m_be <= 4'hF;
      m_wd <= '0; m_ir <= '0; m_dr <= '0;
    end else if (m_age == 0) begin
      if (data_ce) begin
        m_age <= 1; m_own <= 2; m_we <= data_we; m_addr <= data_addr[AW+1:2];
        m_be <= ~data_sel; m_wd <= data_wdata;
      end else if (inst_ce) begin
        m_age <= 1; m_own <= 1; m_we <= 1'b0; m_addr <= inst_addr[AW+1:2];
        m_be <= 4'h0; m_wd <= '0;
      end
    end else if (m_age == W) begin
      if (!m_we && m_own == 1) m_ir <= ram_rdata;
      if (!m_we && m_own == 2) m_dr <= ram_rdata;
      m_age <= W + 1;
    end else if (m_dn) begin
      m_age <= 0; m_own <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          mem;
    logic          we;
    logic [31:0]   addr;
    logic [3:0]    sel;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [AW-1:0] exp_addr;
    logic [3:0]    exp_be_n;
    int            exp_lat;
    logic [31:0]   exp_rd;
    int            exp_oe;
    int            exp_we;
  } vec_t;

  task automatic run_txn(input vec_t v, input string nm);
    int lat, oe_cnt, we_cnt;
    logic served, stall;
    logic [AW-1:0] got_addr;
    logic [3:0] got_be;
    lat = 0; oe_cnt = 0; we_cnt = 0; served = 1'b0; got_addr = '1; got_be = 4'hA;
    tick();
    ram_rdata = v.rdata;
    if (v.mem) begin
      data_ce = 1'b1; data_we = v.we; data_addr = v.addr; data_sel = v.sel; data_wdata = v.wdata;
    end else begin
      inst_ce = 1'b1; inst_addr = v.addr;
    end
    for (int c = 0; c < 20 && !served; c++) begin
      @(negedge clk);
      if (!o_ram_ce_n) begin got_addr = o_ram_addr; got_be = o_ram_be_n; end
      if (!o_ram_oe_n) oe_cnt++;
      if (!o_ram_we_n) we_cnt++;
      stall = v.mem ? o_stallreq_mem : o_stallreq_if;
      if (stall) lat++;
      else begin
        served = 1'b1;
        chk({nm, " done_wdata_oe"}, 32'(o_ram_wdata_oe), 32'(v.we));
        chk({nm, " rdata"}, v.mem ? o_data_rdata : o_inst_rdata, v.exp_rd);
      end
    end
    chk({nm, " served"}, 32'(served), 32'd1);
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " addr"}, 32'(got_addr), 32'(v.exp_addr));
    chk({nm, " be_n"}, 32'(got_be), 32'(v.exp_be_n));
    chk({nm, " oe_cycles"}, oe_cnt, v.exp_oe);
    chk({nm, " we_cycles"}, we_cnt, v.exp_we);
    tick();
    inst_ce = 1'b0; data_ce = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vecs[6];

  initial begin
    int first_mem, first_if_addr, first_if, served, n_acc;
    logic prev_ce_n, srv_if, srv_mem;
    logic [AW-1:0] accs[4];
    int done_cyc[3];

    //            mem  we    addr          sel    wdata         rdata         addr     be_n  lat rd            oe we
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'h2408_0001, 20'h00004, 4'h0, 3, 32'h2408_0001, 2, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h1234_5678, 20'h00040, 4'h0, 3, 32'h1234_5678, 2, 0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0203, 4'h8, 32'hDEAD_BEEF, 32'h7777_7777, 20'h00080, 4'h7, 3, 32'h1234_5678, 0, 2};
    vecs[3] = '{1'b0, 1'b0, 32'hFFC0_0008, 4'hF, 32'h0,        32'hA5A5_0F0F, 20'h00002, 4'h0, 3, 32'hA5A5_0F0F, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0004, 4'h0, 32'h0BAD_0BAD, 32'h6666_6666, 20'h00001, 4'hF, 3, 32'h1234_5678, 0, 2};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,        32'hCAFE_F00D, 20'hFFFFF, 4'h0, 3, 32'hCAFE_F00D, 2, 0};

    rst = 1'b1; inst_ce = 1'b1; inst_addr = 32'h0; data_ce = 1'b0; data_we = 1'b0;
    data_addr = 32'h0; data_sel = 4'h0; data_wdata = 32'h0; ram_rdata = 32'h0;

    // Reset held 3 cycles with a pending fetch.
    repeat (3) begin
      @(negedge clk);
      chk("rst stallreq_if", 32'(o_stallreq_if), 32'd0);
      chk("rst ce_n", 32'(o_ram_ce_n), 32'd1);
      chk("rst oe_n", 32'(o_ram_oe_n), 32'd1);
      chk("rst we_n", 32'(o_ram_we_n), 32'd1);
      chk("rst inst_rdata", o_inst_rdata, 32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first idle stall", 32'(o_stallreq_if), 32'd1);
    @(negedge clk);
    chk("first fetch addr", 32'(o_ram_addr), 32'd0);
    chk("first fetch ce_n", 32'(o_ram_ce_n), 32'd0);
    // Abort in the second ACCESS cycle.
    tick();
    ram_rdata = 32'h1111_1111;
    rst = 1'b1;
    @(negedge clk);
    chk("abort stall forced", 32'(o_stallreq_if), 32'd0);
    tick();
    rst = 1'b0; inst_ce = 1'b0;
    @(negedge clk);
    chk("abort ce_n", 32'(o_ram_ce_n), 32'd1);
    chk("abort oe_n", 32'(o_ram_oe_n), 32'd1);
    chk("abort inst_rdata", o_inst_rdata, 32'd0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous IF and MEM requests.
    tick();
    ram_rdata = 32'h5555_AAAA;
    inst_ce = 1'b1; inst_addr = 32'h0000_0010;
    data_ce = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0100; data_sel = 4'hF;
    first_mem = 0; first_if_addr = 0; first_if = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (first_mem == 0 && data_ce && !o_stallreq_mem) first_mem = c;
      if (first_if_addr == 0 && !o_ram_ce_n && o_ram_addr == 20'h00004) first_if_addr = c;
      if (first_if == 0 && inst_ce && !o_stallreq_if) first_if = c;
      tick();
      if (first_mem == c) data_ce = 1'b0;
      if (first_if == c) inst_ce = 1'b0;
    end
    chk("simul mem served cycle", first_mem, 4);
    chk("simul if addr cycle", first_if_addr, 6);
    chk("simul if served cycle", first_if, 8);
    chk("simul data_rdata", o_data_rdata, 32'h5555_AAAA);
    inst_ce = 1'b0; data_ce = 1'b0;

    // Back-to-back fetches with pc advancing on the completion cycle.
    tick();
    inst_ce = 1'b1; inst_addr = 32'h0; ram_rdata = 32'h0F0F_0F0F;
    served = 0; n_acc = 0; prev_ce_n = 1'b1;
    for (int i = 0; i < 4; i++) accs[i] = '1;
    for (int i = 0; i < 3; i++) done_cyc[i] = 0;
    for (int c = 1; c <= 20 && served < 3; c++) begin
      @(negedge clk);
      if (!o_ram_ce_n && prev_ce_n && n_acc < 4) begin accs[n_acc] = o_ram_addr; n_acc++; end
      prev_ce_n = o_ram_ce_n;
      srv_if = inst_ce && !o_stallreq_if;
      if (srv_if) begin done_cyc[served] = c; served++; end
      tick();
      if (srv_if) begin
        if (served < 3) inst_addr = inst_addr + 32'd4;
        else inst_ce = 1'b0;
      end
    end
    inst_ce = 1'b0;
    chk("b2b sram cycles", n_acc, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b addr%0d", i), 32'(accs[i]), i);
      chk($sformatf("b2b done%0d", i), done_cyc[i], 4 * (i + 1));
    end

    // Randomized traffic obeying the hold-while-stalled protocol.
    srv_if = 1'b0; srv_mem = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      srv_if  = !rst && inst_ce && !o_stallreq_if;
      srv_mem = !rst && data_ce && !o_stallreq_mem;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      ram_rdata = $urandom;
      if (!inst_ce) begin
        if ($urandom_range(0, 1) == 1) begin inst_ce = 1'b1; inst_addr = $urandom; end
      end else if (srv_if) begin
        if ($urandom_range(0, 3) != 0) inst_addr = inst_addr + 32'd4;
        else inst_ce = 1'b0;
      end else if ($urandom_range(0, 29) == 0) inst_ce = 1'b0;
      if (!data_ce || srv_mem) begin
        data_ce = ($urandom_range(0, 2) != 0);
        data_we = $urandom_range(0, 1) == 1;
        data_addr = $urandom;
        data_sel = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
      end else if ($urandom_range(0, 29) == 0) data_ce = 1'b0;
    end
    rst = 1'b0; inst_ce = 1'b0; data_ce = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external single-port SRAM (32-bit word, async-style control, active-low strobes) between the IF port (driven by pc/ce from the PC stage) and the MEM-stage load/store port.
- Runs a multi-cycle access FSM and raises per-port stall requests into the pipeline control module, which folds them into stall[5:0].
- MEM has fixed priority over IF; an access in progress is never pre-empted.

Parameters:
- WAIT_CYCLES, 2, number of cycles strobes are held active per access (>=1).
- RAM_AW, 20, SRAM word-address width; ram_addr = addr[RAM_AW+1:2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high (`RstEnable = 1'b1).
- inst_ce  in  1  IF request (PC-stage ce).
- inst_addr  in  32  IF byte address (pc).
- inst_rdata  out  32  fetched instruction.
- stallreq_if  out  1  IF not yet served.
- data_ce  in  1  MEM request.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  32  MEM byte address.
- data_sel  in  4  byte enables, active-high.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data.
- stallreq_mem  out  1  MEM not yet served.
- ram_addr  out  RAM_AW  SRAM word address.
- ram_be_n  out  4  byte enables, active-low.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- ram_wdata  out  32  write data.
- ram_wdata_oe  out  1  top-level tristate enable for the data bus.
- ram_rdata  in  32  SRAM read data.

Behaviour:
- Reset (sampled at posedge): state=IDLE; owner=NONE; cnt=0; ram_ce_n/oe_n/we_n=1; ram_be_n=4'hF; ram_addr=0; ram_wdata=0; ram_wdata_oe=0; inst_rdata=0; data_rdata=0. stallreq_if and stallreq_mem are forced to 0 while rst=1. Reset mid-access aborts the access and ignores any partial data.
- States:
  - IDLE: grant MEM if data_ce, else IF if inst_ce, else stay. On grant, latch owner, word address, be_n (IF: 4'h0; MEM: ~data_sel), wdata, and we. Go to ACCESS with cnt=0.
  - ACCESS: ce_n=0 for all cycles. Load/fetch: oe_n=0. Store: we_n=0 and wdata_oe=1. cnt increments each cycle. When cnt==WAIT_CYCLES-1, capture ram_rdata into the owner's rdata register (reads only) and go to DONE.
  - DONE: all strobes deasserted. Address and wdata are held, with wdata_oe=1 held for stores (hold time). Always return to IDLE next cycle.
- Stall rules:
  - stallreq_if = inst_ce & ~(state==DONE & owner==IF).
  - stallreq_mem = data_ce & ~(state==DONE & owner==MEM).
  - Requesters hold ce/addr/data stable while stalled. The DONE cycle is the single cycle the pipeline may advance past the request.
- Latency: an unloaded access takes 1 (IDLE) + WAIT_CYCLES + 1 (DONE) cycles. With WAIT_CYCLES=2, stallreq is high for 3 cycles and low in the 4th.
- Read data: the rdata registers hold their value until the next capture for the same port. A store never alters data_rdata.
- Simultaneous requests: MEM first. IF then waits at least one full access plus its own. IF re-arbitrates in the IDLE following MEM's DONE.
- Requests arriving during ACCESS or DONE are not sampled until IDLE. There is no pre-emption.
- A request withdrawn (ce=0) mid-access still completes the SRAM cycle. The result is captured but no stall is raised.
- Address wrap: only addr[RAM_AW+1:2] is used. Upper bits are ignored, with no fault.
- data_sel=4'h0 with data_we=1 performs a cycle with no bytes written (be_n=4'hF).

Decomposition:
- Add to define.v:
  - state encodings ArbIdle, ArbAccess, ArbDone.
  - owner codes OwnNone, OwnIf, OwnMem.
  - macro RamAddrBus.
- Reuse existing `RstEnable, `ChipEnable, `RegBus, `InstAddrBus.
- Implement as a single module with no sub-module. The wait counter is small enough to inline.

Test Plan:
- Reset held 3 cycles with inst_ce=1: all strobes 1, stallreq_if=0, inst_rdata=0. After release, the first fetch of addr 0x0000_0000 drives ram_addr=0.
- IF fetch 0x0000_0010, ram_rdata=0x2408_0001, WAIT_CYCLES=2: stallreq_if high for 3 cycles, low in cycle 4 with inst_rdata=0x2408_0001 and oe_n=0 only in the 2 ACCESS cycles.
- Same-cycle inst_ce=1 and data_ce=1 (load 0x0000_0100): MEM served first, stallreq_mem drops at cycle 4. IF ram_addr=0x00004 appears at cycle 6, and stallreq_if drops at cycle 8.
- Store 0xDEADBEEF to 0x0000_0203 with sel=4'b1000: ram_addr=0x00080, be_n=4'b0111, we_n=0 for 2 cycles, wdata_oe=1 through DONE, and data_rdata unchanged.
- Assert rst during the second ACCESS cycle: next cycle is IDLE, strobes high, rdata unchanged. A subsequent request restarts the full latency.
- Back-to-back IF fetches 0x0, 0x4, 0x8 with pc advancing on DONE: exactly 3 SRAM cycles, each 4 cycles long, with no duplicated or skipped address.
